angle_sweep_ctrl: RTL and testbench

Sequencer that sweeps the angle ROM (0..360 degree table, one 32-bit word per address) over a programmed address range. For each address it fetches the word, issues it to the CORDIC core with a start pulse and waits for the core's done. It owns the ROM's ce/read_en and is the only driver of the CORDIC core's angle/start inputs.

---
 rtl/angle_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_angle_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_sweep_ctrl.sv
// Sweeps the angle ROM over [cfg_start..cfg_end] by cfg_step and issues each word to the CORDIC core. Optional macro: ANGLE_SWEEP_TIMEOUT_EN.
// Latency: start accepted at edge N -> cordic_start in cycle N+2; each sample costs 2 cycles plus CORDIC latency.
// Backpressure: waits in WAIT for cordic_done (indefinitely unless the watchdog macro is defined); start is ignored while busy.
module angle_sweep_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MAX_ADDR    = 360,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_start,
    input  logic [ADDR_W-1:0] cfg_end,
    input  logic [ADDR_W-1:0] cfg_step,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    output logic              rom_read_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] cordic_angle,
    output logic              cordic_start,
    input  logic              cordic_done,
    output logic              busy,
    output logic              sweep_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] sample_idx,
    output logic              timeout_err
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_A = (ADDR_W+1)'(MAX_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, end_q, step_q, idx_q;
    logic [DATA_W-1:0] angle_q;
    logic              cfg_err_q, tmo_err_q;
    logic              cfg_ok, accept, advance, tmo_hit;
    logic [ADDR_W:0]   nxt;
    logic              last;

    assign cfg_ok = (cfg_step != '0) && (cfg_start <= cfg_end) && ({1'b0, cfg_end} <= MAX_A);
    // One extra bit so cur+step can never wrap back into the valid range.
    assign nxt    = {1'b0, cur_q} + {1'b0, step_q};
    assign last   = nxt > {1'b0, end_q};

`ifdef ANGLE_SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q == S_WAIT) && !cordic_done && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tmo_cnt_q <= '0;
        else if (state_q != S_WAIT) tmo_cnt_q <= '0;
        else                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && cfg_ok) begin
                    accept  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (cordic_done) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            end_q     <= '0;
            step_q    <= '0;
            idx_q     <= '0;
            angle_q   <= '0;
            cfg_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
            tmo_err_q <= tmo_hit && !abort;
            if (accept) begin
                cur_q  <= cfg_start;
                end_q  <= cfg_end;
                step_q <= cfg_step;
                idx_q  <= '0;
            end
            if (advance)
                cur_q <= nxt[ADDR_W-1:0];
            if (state_q == S_FETCH && !abort)
                angle_q <= rom_data;
            // The pulse was already driven this cycle, so it counts even if abort arrives with it.
            if (state_q == S_ISSUE)
                idx_q <= idx_q + 1'b1;
        end
    end

    assign rom_addr     = cur_q;
    assign rom_ce       = (state_q == S_FETCH);
    assign rom_read_en  = (state_q == S_FETCH);
    assign cordic_angle = angle_q;
    assign cordic_start = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign sweep_done   = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;
    assign sample_idx   = idx_q;
    assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_angle_sweep_ctrl.sv
// Scoreboard bench for angle_sweep_ctrl: stimulus pushes expected issues/completions, a negedge monitor pops and compares.
module tb_angle_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [9:0]  cfg_start, cfg_end, cfg_step;
    logic [9:0]  rom_addr;
    logic        rom_ce, rom_read_en;
    logic [31:0] rom_data;
    logic [31:0] cordic_angle;
    logic        cordic_start, cordic_done;
    logic        busy, sweep_done, cfg_err, timeout_err;
    logic [9:0]  sample_idx;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] addr;
        logic [9:0] idx;
    } iss_t;

    iss_t exp_iss[$];
    int   exp_done[$];
    int   cerr_pend = 0;
    int   tmo_pend  = 0;
    bit   no_fetch  = 0;
    bit   mute      = 0;
    int   lat       = 3;

    always #5 clk = ~clk;

    angle_sweep_ctrl #(.ADDR_W(10), .DATA_W(32), .MAX_ADDR(360), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step),
        .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_data(rom_data),
        .cordic_angle(cordic_angle), .cordic_start(cordic_start), .cordic_done(cordic_done),
        .busy(busy), .sweep_done(sweep_done), .cfg_err(cfg_err),
        .sample_idx(sample_idx), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'h5A00_0000 + 32'(a) * 32'd997;
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_iss(input logic [9:0] a, input logic [9:0] i);
        iss_t e;
        e.addr = a;
        e.idx  = i;
        exp_iss.push_back(e);
    endtask

    // CORDIC model: done pulses 'lat' cycles after each start unless muted.
    initial begin
        int dcnt;
        dcnt = 0;
        cordic_done = 1'b0;
        forever begin
            @(negedge clk);
            cordic_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) cordic_done = 1'b1;
            end
            if (cordic_start && !mute) dcnt = lat;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cordic_start) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", {22'd0, rom_addr}, 32'hFFFF_FFFF);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("issue_addr", {22'd0, rom_addr}, {22'd0, e.addr});
                    chk("issue_angle", cordic_angle, rom_word(e.addr));
                    chk("issue_idx", {22'd0, sample_idx}, {22'd0, e.idx});
                end
            end
            if (sweep_done) begin
                if (exp_done.size() == 0) chk("unexpected_sweep_done", 32'd1, 32'd0);
                else chk("done_idx", {22'd0, sample_idx}, 32'(exp_done.pop_front()));
            end
            if (cfg_err) begin
                if (cerr_pend == 0) chk("unexpected_cfg_err", 32'd1, 32'd0);
                else begin
                    cerr_pend--;
                    chk("cfg_err_busy", {31'd0, busy}, 32'd0);
                end
            end
            if (timeout_err) begin
                if (tmo_pend == 0) chk("unexpected_timeout", 32'd1, 32'd0);
                else tmo_pend--;
            end
            if (rom_ce) begin
                if (rom_addr > 10'd360) chk("rom_addr_range", {22'd0, rom_addr}, 32'd360);
                if (no_fetch) chk("rom_ce_on_invalid", 32'd1, 32'd0);
            end
        end
    end

    task automatic sweep(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st);
        cfg_start = s;
        cfg_end   = e;
        cfg_step  = st;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_step = '0;
        #1;
        chk("rst_busy",        {31'd0, busy},         32'd0);
        chk("rst_rom_addr",    {22'd0, rom_addr},     32'd0);
        chk("rst_angle",       cordic_angle,          32'd0);
        chk("rst_idx",         {22'd0, sample_idx},   32'd0);
        chk("rst_rom_ce",      {31'd0, rom_ce},       32'd0);
        chk("rst_rom_rd",      {31'd0, rom_read_en},  32'd0);
        chk("rst_cstart",      {31'd0, cordic_start}, 32'd0);
        chk("rst_sdone",       {31'd0, sweep_done},   32'd0);
        chk("rst_cfg_err",     {31'd0, cfg_err},      32'd0);
        chk("rst_timeout",     {31'd0, timeout_err},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while waiting on the core
        mute = 1;
        push_iss(10'd0, 10'd0);
        sweep(10'd0, 10'd360, 10'd90);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, busy},       32'd0);
        chk("midrst_angle", cordic_angle,        32'd0);
        chk("midrst_idx",   {22'd0, sample_idx}, 32'd0);
        chk("midrst_addr",  {22'd0, rom_addr},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mute  = 0;
        @(negedge clk);

        // Full sweep 0..360 step 90, with an ignored start mid-sweep
        push_iss(10'd0, 10'd0);
        push_iss(10'd90, 10'd1);
        push_iss(10'd180, 10'd2);
        push_iss(10'd270, 10'd3);
        push_iss(10'd360, 10'd4);
        exp_done.push_back(5);
        sweep(10'd0, 10'd360, 10'd90);
        repeat (3) @(negedge clk);
        sweep(10'd5, 10'd6, 10'd1);
        cfg_start = 10'd100; cfg_end = 10'd101; cfg_step = 10'd7;
        wait_idle("sweep90", 200);
        chk("sweep90_idx_after", {22'd0, sample_idx}, 32'd5);
        @(negedge clk);

        // Step overshoots the end bound immediately
        push_iss(10'd355, 10'd0);
        exp_done.push_back(1);
        sweep(10'd355, 10'd360, 10'd10);
        wait_idle("single", 50);
        @(negedge clk);

        // Rejected configurations
        no_fetch = 1;
        cerr_pend++; sweep(10'd0,  10'd100, 10'd0);  @(negedge clk);
        chk("bad_step_busy",  {31'd0, busy}, 32'd0);
        cerr_pend++; sweep(10'd20, 10'd10,  10'd1);  @(negedge clk);
        chk("bad_order_busy", {31'd0, busy}, 32'd0);
        cerr_pend++; sweep(10'd0,  10'd361, 10'd1);  @(negedge clk);
        chk("bad_end_busy",   {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        no_fetch = 0;
        chk("cfg_err_count", 32'(cerr_pend), 32'd0);

        // Abort during WAIT of the second sample
        push_iss(10'd0, 10'd0);
        push_iss(10'd90, 10'd1);
        sweep(10'd0, 10'd360, 10'd90);
        begin
            int n;
            n = 0;
            while (!(cordic_start && rom_addr == 10'd90) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("abort_second_issue_seen", 32'd0, 32'd1);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",   {31'd0, busy},       32'd0);
        chk("abort_idx",    {22'd0, sample_idx}, 32'd2);
        chk("abort_angle",  cordic_angle,        rom_word(10'd90));
        chk("abort_rom_ce", {31'd0, rom_ce},     32'd0);
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        // Core never answers
        mute = 1;
        push_iss(10'd0, 10'd0);
        sweep(10'd0, 10'd360, 10'd90);
`ifdef ANGLE_SWEEP_TIMEOUT_EN
        tmo_pend = 1;
        repeat (9) @(negedge clk);
        chk("tmo_last_wait_busy", {31'd0, busy},        32'd1);
        chk("tmo_not_yet",        {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        chk("tmo_err",            {31'd0, timeout_err}, 32'd1);
        chk("tmo_busy",           {31'd0, busy},        32'd0);
        @(negedge clk);
        chk("tmo_pulse_len",      {31'd0, timeout_err}, 32'd0);
        chk("tmo_count",          32'(tmo_pend),        32'd0);
`else
        repeat (30) @(negedge clk);
        chk("hang_busy",    {31'd0, busy},        32'd1);
        chk("hang_timeout", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        mute = 0;
        repeat (2) @(negedge clk);

        chk("issues_left", 32'(exp_iss.size()),  32'd0);
        chk("dones_left",  32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "global timeout");
    end

endmodule
